exe_mem_sram_ctrl: RTL and testbench
====================================

Name: exe_mem_sram_ctrl

Overview:
- Sequences each memory access issued by the EXE stage (mem_read/mem_write, with alu_res as address) onto a 16-bit-wide, multi-cycle external SRAM.
- Splits every 32-bit word access into two halfword phases.
- Drives a ready/freeze signal that stalls the pipeline until the access completes.
- Sits between the EXE/MEM pipeline register and the SRAM pins, replacing the single-cycle data memory.

Parameters:
- WAIT_CYCLES, 3: cycles each halfword phase holds the SRAM address/control; minimum 1.
- BASE_ADDR, 1024: byte address mapped to SRAM word 0.
- SRAM_ADDR_LEN, 18: SRAM halfword address width.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous, active-low reset.
- mem_read  in  1  read request from the EXE/MEM register.
- mem_write  in  1  write request from the EXE/MEM register.
- address  in  REGISTER_LEN  byte address (alu_res).
- wdata  in  REGISTER_LEN  store data (val_rm).
- rdata  out  REGISTER_LEN  load data; valid in the DONE cycle.
- ready  out  1  high means the pipeline may advance; low freezes all stages.
- sram_addr  out  SRAM_ADDR_LEN  halfword address.
- sram_dq_out  out  16  write data to the pad.
- sram_dq_in  in  16  read data from the pad.
- sram_dq_oe  out  1  pad output enable.
- sram_we_n  out  1  active-low write enable.
- addr_err  out  1  present only with SRAM_ADDR_CHECK_EN.

Behaviour:
- Reset (rst=0, asynchronous):
  - state=IDLE, counter=0, rdata=0.
  - sram_addr=0, sram_dq_out=0, sram_dq_oe=0, sram_we_n=1, addr_err=0.
  - A reset mid-access aborts the access immediately; no partial-completion signalling.
- Address translation:
  - word = (address - BASE_ADDR) >> 2.
  - Low phase uses sram_addr = {word,0}; high phase uses {word,1}.
  - Result is truncated to SRAM_ADDR_LEN. Subtraction wraps modulo 2^32.
- States: IDLE, LO, HI, DONE.
  - IDLE: a request sampled at a clock edge moves to LO and loads counter = WAIT_CYCLES-1.
  - LO: counter decrements each cycle. At counter==0 the next edge moves to HI, reloads the counter, and (for a read) captures sram_dq_in into rdata[15:0].
  - HI: same as LO; at counter==0 the next edge moves to DONE and (for a read) captures rdata[31:16].
  - DONE: one cycle, then IDLE unconditionally.
- ready = (state==DONE) | (state==IDLE & ~mem_read & ~mem_write). Combinational.
- Latency: a request first presented in cycle c keeps ready low for 2*WAIT_CYCLES+1 cycles; ready=1 in cycle c+2*WAIT_CYCLES+1 (DONE).
- Request stability:
  - mem_read, mem_write, address and wdata must be held stable while ready=0.
  - Values are latched at the IDLE->LO edge, so later changes are ignored.
- Write:
  - sram_dq_oe=1 and sram_we_n=0 for every LO/HI cycle.
  - LO drives sram_dq_out=wdata[15:0]; HI drives wdata[31:16].
  - sram_we_n=1 in IDLE and DONE.
- Read: sram_dq_oe=0 and sram_we_n=1 throughout. rdata holds its value until the next read completes.
- Simultaneous mem_read and mem_write: treated as a write.
- Back-to-back requests: after DONE the block spends at least one IDLE cycle. A request still asserted in that IDLE cycle starts a new access; ready=0 in that cycle.

Optional Feature:
- Macro: SRAM_ADDR_CHECK_EN.
- With the macro:
  - A request whose address[1:0]!=0, or whose address < BASE_ADDR, or whose word index overflows the SRAM, skips LO/HI and goes IDLE->DONE. Ready is low for 1 cycle.
  - In that DONE cycle addr_err=1 and rdata is unchanged; no SRAM cycle is issued.
  - Simultaneous read and write also sets addr_err; the write is still performed.
- Without the macro: no addr_err port, no checks; the address LSBs are ignored.

Decomposition:
- Add to the shared defines: SRAM_DATA_LEN=16, SRAM_ADDR_LEN default, and the state encodings (2 bits: IDLE=0, LO=1, HI=2, DONE=3).
- REGISTER_LEN is reused from the existing defines.
- One sub-module: sram_wait_counter. It provides a loadable down-counter with a zero flag, sized clog2(WAIT_CYCLES)+1.

Test Plan:
- Write 0xDEADBEEF to address 1024 with WAIT_CYCLES=3 -> sram_addr 0 with BEEF and we_n=0 for 3 cycles, then sram_addr 1 with DEAD for 3 cycles. ready=0 for 7 cycles and 1 in the 7th cycle after the request.
- Read address 1024 with the bench SRAM model returning BEEF/DEAD -> rdata=0xDEADBEEF in the DONE cycle; we_n=1 and dq_oe=0 throughout.
- Write 0x12345678 to 1028, then read 1028 back-to-back -> sram_addr 2/3 used, one IDLE cycle between accesses, rdata=0x12345678.
- Pull rst low during the HI phase of a write -> we_n=1 and dq_oe=0 immediately. After release, state=IDLE and ready=1 with no request.
- mem_read=mem_write=1, address 1032, wdata 0xA5A5 -> treated as a write to sram_addr 4/5. With SRAM_ADDR_CHECK_EN, addr_err=1 in DONE.
- With SRAM_ADDR_CHECK_EN: read address 1026, then address 512 -> each completes in 2 cycles with addr_err=1, no SRAM activity, rdata unchanged.

Source files
------------

// File: rtl/exe_mem_sram_ctrl_pkg.sv
// Shared types and constants for the EXE/MEM stage SRAM controller.
package exe_mem_sram_ctrl_pkg;

  localparam int unsigned REGISTER_LEN      = 32;
  localparam int unsigned SRAM_DATA_LEN     = 16;
  localparam int unsigned SRAM_ADDR_LEN_DEF = 18;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LO   = 2'd1,
    ST_HI   = 2'd2,
    ST_DONE = 2'd3
  } sram_state_e;

  // Request captured at the IDLE->LO edge and held for the whole access
  typedef struct packed {
    logic                    wr;
    logic [REGISTER_LEN-1:0] wdata;
  } sram_req_t;

  function automatic logic is_phase(input sram_state_e st);
    return (st == ST_LO) || (st == ST_HI);
  endfunction

endpackage

// File: rtl/exe_mem_sram_ctrl_wait_counter.sv
// Loadable down-counter with zero flag that times each SRAM halfword phase.
module sram_wait_counter #(
  parameter int unsigned CNT_W = 3
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic             dec,
  input  logic [CNT_W-1:0] load_val,
  output logic             zero_c
);

  logic [CNT_W-1:0] count;

  // Load wins over decrement so a phase change reloads cleanly
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      count <= '0;
    end else if (load) begin
      count <= load_val;
    end else if (dec && (count != '0)) begin
      count <= count - CNT_W'(1);
    end
  end

  assign zero_c = (count == '0);

endmodule

// File: rtl/exe_mem_sram_ctrl.sv
// Sequences EXE-stage word accesses onto a 16-bit multi-cycle SRAM as two halfword phases.
// Optional SRAM_ADDR_CHECK_EN adds address checking and the addr_err output.
module exe_mem_sram_ctrl
  import exe_mem_sram_ctrl_pkg::*;
#(
  parameter int unsigned WAIT_CYCLES   = 3,
  parameter int unsigned BASE_ADDR     = 1024,
  parameter int unsigned SRAM_ADDR_LEN = SRAM_ADDR_LEN_DEF
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     mem_read,
  input  logic                     mem_write,
  input  logic [REGISTER_LEN-1:0]  address,
  input  logic [REGISTER_LEN-1:0]  wdata,
  output logic [REGISTER_LEN-1:0]  rdata,
  output logic                     ready,
  output logic [SRAM_ADDR_LEN-1:0] sram_addr,
  output logic [SRAM_DATA_LEN-1:0] sram_dq_out,
  input  logic [SRAM_DATA_LEN-1:0] sram_dq_in,
  output logic                     sram_dq_oe,
  output logic                     sram_we_n
`ifdef SRAM_ADDR_CHECK_EN
  ,
  output logic                     addr_err
`endif
);

  localparam int unsigned CNT_W  = $clog2(WAIT_CYCLES) + 1;
  localparam int unsigned WORD_W = SRAM_ADDR_LEN - 1;

  sram_state_e              state_q, state_d;
  sram_req_t                req_q, req_d;
  logic [WORD_W-1:0]        word_q, word_d;
  logic [REGISTER_LEN-1:0]  rdata_d;
  logic [SRAM_ADDR_LEN-1:0] sram_addr_d;
  logic [SRAM_DATA_LEN-1:0] sram_dq_out_d;
  logic                     sram_dq_oe_d;
  logic                     sram_we_n_d;
  logic                     cnt_load, cnt_dec, cnt_zero;
  logic                     req_c, skip_c;
  logic [REGISTER_LEN-1:0]  offset;
  logic                     unused_offset;

  assign req_c  = mem_read | mem_write;
  assign offset = address - REGISTER_LEN'(BASE_ADDR);
  assign unused_offset = ^{offset[1:0], offset[REGISTER_LEN-1:SRAM_ADDR_LEN+1]};
  assign ready  = (state_q == ST_DONE) | ((state_q == ST_IDLE) & ~req_c);

  sram_wait_counter #(.CNT_W(CNT_W)) u_wait_counter (
    .clk      (clk),
    .rst      (rst),
    .load     (cnt_load),
    .dec      (cnt_dec),
    .load_val (CNT_W'(WAIT_CYCLES - 1)),
    .zero_c   (cnt_zero)
  );

`ifdef SRAM_ADDR_CHECK_EN
  logic bad_addr, err_q, err_d, addr_err_d;

  // Misaligned, below the SRAM window, or past the last SRAM word
  assign bad_addr = (|address[1:0]) ||
                    (address < REGISTER_LEN'(BASE_ADDR)) ||
                    (|offset[REGISTER_LEN-1:SRAM_ADDR_LEN+1]);
  assign skip_c   = bad_addr;

  always_comb begin
    err_d = err_q;
    if ((state_q == ST_IDLE) && req_c) begin
      err_d = bad_addr | (mem_read & mem_write);
    end
    addr_err_d = (state_d == ST_DONE) & err_d;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      err_q    <= 1'b0;
      addr_err <= 1'b0;
    end else begin
      err_q    <= err_d;
      addr_err <= addr_err_d;
    end
  end
`else
  assign skip_c = 1'b0;
`endif

  // Next-state, request latch, read capture and pad outputs aligned with state_d
  always_comb begin
    state_d  = state_q;
    req_d    = req_q;
    word_d   = word_q;
    rdata_d  = rdata;
    cnt_load = 1'b0;
    cnt_dec  = 1'b0;

    unique case (state_q)
      ST_IDLE: begin
        if (req_c) begin
          req_d.wr    = mem_write;
          req_d.wdata = wdata;
          word_d      = offset[SRAM_ADDR_LEN:2];
          if (skip_c) begin
            state_d = ST_DONE;
          end else begin
            state_d  = ST_LO;
            cnt_load = 1'b1;
          end
        end
      end
      ST_LO: begin
        cnt_dec = 1'b1;
        if (cnt_zero) begin
          state_d  = ST_HI;
          cnt_load = 1'b1;
          if (!req_q.wr) rdata_d[SRAM_DATA_LEN-1:0] = sram_dq_in;
        end
      end
      ST_HI: begin
        cnt_dec = 1'b1;
        if (cnt_zero) begin
          state_d = ST_DONE;
          if (!req_q.wr) rdata_d[REGISTER_LEN-1:SRAM_DATA_LEN] = sram_dq_in;
        end
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase

    sram_addr_d   = sram_addr;
    sram_dq_out_d = sram_dq_out;
    if (state_d == ST_LO) begin
      sram_addr_d = {word_d, 1'b0};
      if (req_d.wr) sram_dq_out_d = req_d.wdata[SRAM_DATA_LEN-1:0];
    end else if (state_d == ST_HI) begin
      sram_addr_d = {word_d, 1'b1};
      if (req_d.wr) sram_dq_out_d = req_d.wdata[REGISTER_LEN-1:SRAM_DATA_LEN];
    end
    sram_dq_oe_d = req_d.wr & is_phase(state_d);
    sram_we_n_d  = ~sram_dq_oe_d;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= ST_IDLE;
      req_q       <= '0;
      word_q      <= '0;
      rdata       <= '0;
      sram_addr   <= '0;
      sram_dq_out <= '0;
      sram_dq_oe  <= 1'b0;
      sram_we_n   <= 1'b1;
    end else begin
      state_q     <= state_d;
      req_q       <= req_d;
      word_q      <= word_d;
      rdata       <= rdata_d;
      sram_addr   <= sram_addr_d;
      sram_dq_out <= sram_dq_out_d;
      sram_dq_oe  <= sram_dq_oe_d;
      sram_we_n   <= sram_we_n_d;
    end
  end

endmodule

// File: tb/tb_exe_mem_sram_ctrl.sv
// Scoreboard bench for exe_mem_sram_ctrl with a small behavioural SRAM.
module tb_exe_mem_sram_ctrl;

  localparam int unsigned W   = 3;
  localparam int          LAT = 2 * W + 1;
`ifdef SRAM_ADDR_CHECK_EN
  localparam logic CHK = 1'b1;
`else
  localparam logic CHK = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst;
  logic        mem_read, mem_write;
  logic [31:0] address, wdata, rdata;
  logic        ready;
  logic [17:0] sram_addr;
  logic [15:0] sram_dq_out, sram_dq_in;
  logic        sram_dq_oe, sram_we_n;
`ifdef SRAM_ADDR_CHECK_EN
  logic        addr_err;
`endif

  typedef struct {
    int          lat;
    logic [17:0] lo_addr;
    logic [17:0] hi_addr;
    logic        wr;
    logic [15:0] lo_data;
    logic [15:0] hi_data;
    int          n_phase;
    logic [31:0] rdata;
    logic        err;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;

  exe_mem_sram_ctrl #(.WAIT_CYCLES(W), .BASE_ADDR(1024), .SRAM_ADDR_LEN(18)) dut (
    .clk         (clk),
    .rst         (rst),
    .mem_read    (mem_read),
    .mem_write   (mem_write),
    .address     (address),
    .wdata       (wdata),
    .rdata       (rdata),
    .ready       (ready),
    .sram_addr   (sram_addr),
    .sram_dq_out (sram_dq_out),
    .sram_dq_in  (sram_dq_in),
    .sram_dq_oe  (sram_dq_oe),
    .sram_we_n   (sram_we_n)
`ifdef SRAM_ADDR_CHECK_EN
    ,
    .addr_err    (addr_err)
`endif
  );

  always #5 clk = ~clk;

  // Behavioural SRAM: writes on the clock, reads combinationally
  logic [15:0] sram_mem [64];
  always @(posedge clk) begin
    if (!sram_we_n && sram_dq_oe) sram_mem[6'(sram_addr)] <= sram_dq_out;
  end
  assign sram_dq_in = sram_mem[6'(sram_addr)];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", nm, act, exp);
    end
  endtask

  function automatic exp_t mk(input int lat, input logic [17:0] lo, input logic [17:0] hi,
                              input logic wr, input logic [15:0] lod, input logic [15:0] hid,
                              input int nph, input logic [31:0] rd, input logic err);
    exp_t e;
    e.lat = lat; e.lo_addr = lo; e.hi_addr = hi; e.wr = wr;
    e.lo_data = lod; e.hi_data = hid; e.n_phase = nph; e.rdata = rd; e.err = err;
    return e;
  endfunction

  // Monitor: tracks one access at a time, compares on the DONE cycle
  exp_t cur;
  bit   busy = 1'b0;
  int   lat, n_lo, n_hi;

  function automatic logic phase_ok(input logic [17:0] a, input logic [15:0] d);
    if (sram_addr !== a) return 1'b0;
    if (cur.wr) return !sram_we_n && sram_dq_oe && (sram_dq_out === d);
    return sram_we_n && !sram_dq_oe;
  endfunction

  always @(negedge clk) begin
    if (!rst) begin
      if (busy && sb.size() > 0) void'(sb.pop_front());
      busy = 1'b0;
    end else if (!busy) begin
      if ((mem_read || mem_write) && !ready) begin
        if (sb.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_access: addr 0x%08h with no expectation queued", address);
        end else begin
          cur  = sb[0];
          busy = 1'b1;
          lat  = 1;
          n_lo = 0;
          n_hi = 0;
        end
      end
    end else if (!ready) begin
      lat++;
      if (phase_ok(cur.lo_addr, cur.lo_data)) n_lo++;
      if (phase_ok(cur.hi_addr, cur.hi_data)) n_hi++;
    end else begin
      void'(sb.pop_front());
      busy = 1'b0;
      chk("latency", 32'(lat), 32'(cur.lat));
      chk("lo_phase_cycles", 32'(n_lo), 32'(cur.n_phase));
      chk("hi_phase_cycles", 32'(n_hi), 32'(cur.n_phase));
      chk("rdata", rdata, cur.rdata);
      chk("done_we_n", 32'(sram_we_n), 32'(1));
`ifdef SRAM_ADDR_CHECK_EN
      chk("addr_err", 32'(addr_err), 32'(cur.err));
`endif
    end
  end

  task automatic issue(input logic rd, input logic wr, input logic [31:0] a,
                       input logic [31:0] d, input exp_t e);
    int n;
    sb.push_back(e);
    @(posedge clk); #1;
    mem_read = rd; mem_write = wr; address = a; wdata = d;
    n = 0;
    @(negedge clk);
    while (!ready && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (!ready) begin
      checks++;
      errors++;
      $display("FAIL timeout: ready still 0 after %0d cycles, addr 0x%08h", n, a);
    end
  endtask

  task automatic drop_req();
    @(posedge clk); #1;
    mem_read = 1'b0; mem_write = 1'b0;
  endtask

  initial begin
    rst = 1'b1; mem_read = 1'b0; mem_write = 1'b0; address = '0; wdata = '0;
    #2 rst = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_ready", 32'(ready), 32'(1));
    chk("rst_we_n", 32'(sram_we_n), 32'(1));
    chk("rst_dq_oe", 32'(sram_dq_oe), 32'(0));
    chk("rst_rdata", rdata, 32'h0);
    chk("rst_sram_addr", 32'(sram_addr), 32'(0));
    chk("rst_dq_out", 32'(sram_dq_out), 32'(0));
`ifdef SRAM_ADDR_CHECK_EN
    chk("rst_addr_err", 32'(addr_err), 32'(0));
`endif
    @(negedge clk) rst = 1'b1;

    issue(1'b0, 1'b1, 32'd1024, 32'hDEADBEEF, mk(LAT, 18'd0, 18'd1, 1'b1, 16'hBEEF, 16'hDEAD, W, 32'h0, 1'b0));
    drop_req();
    issue(1'b1, 1'b0, 32'd1024, 32'h0, mk(LAT, 18'd0, 18'd1, 1'b0, 16'h0, 16'h0, W, 32'hDEADBEEF, 1'b0));
    drop_req();

    // Back-to-back write then read of the same word
    issue(1'b0, 1'b1, 32'd1028, 32'h12345678, mk(LAT, 18'd2, 18'd3, 1'b1, 16'h5678, 16'h1234, W, 32'hDEADBEEF, 1'b0));
    issue(1'b1, 1'b0, 32'd1028, 32'h0, mk(LAT, 18'd2, 18'd3, 1'b0, 16'h0, 16'h0, W, 32'h12345678, 1'b0));
    drop_req();

    issue(1'b1, 1'b1, 32'd1032, 32'h0000A5A5, mk(LAT, 18'd4, 18'd5, 1'b1, 16'hA5A5, 16'h0000, W, 32'h12345678, CHK));
    drop_req();
    issue(1'b1, 1'b0, 32'd1032, 32'h0, mk(LAT, 18'd4, 18'd5, 1'b0, 16'h0, 16'h0, W, 32'h0000A5A5, 1'b0));
    drop_req();

`ifdef SRAM_ADDR_CHECK_EN
    issue(1'b1, 1'b0, 32'd1026, 32'h0, mk(1, 18'd0, 18'd1, 1'b0, 16'h0, 16'h0, 0, 32'h0000A5A5, 1'b1));
    drop_req();
    issue(1'b1, 1'b0, 32'd512, 32'h0, mk(1, 18'd0, 18'd1, 1'b0, 16'h0, 16'h0, 0, 32'h0000A5A5, 1'b1));
    drop_req();
`else
    // Byte offset bits are ignored: 1026 reads word 0
    issue(1'b1, 1'b0, 32'd1026, 32'h0, mk(LAT, 18'd0, 18'd1, 1'b0, 16'h0, 16'h0, W, 32'hDEADBEEF, 1'b0));
    drop_req();
`endif

    // Reset during the HI phase of a write
    sb.push_back(mk(LAT, 18'd6, 18'd7, 1'b1, 16'hF00D, 16'hCAFE, W, 32'h0, 1'b0));
    @(posedge clk); #1;
    mem_write = 1'b1; address = 32'd1036; wdata = 32'hCAFEF00D;
    repeat (W + 1) @(posedge clk);
    #2;
    chk("hi_addr_before_reset", 32'(sram_addr), 32'(7));
    chk("hi_we_n_before_reset", 32'(sram_we_n), 32'(0));
    rst = 1'b0;
    #1;
    chk("abort_we_n", 32'(sram_we_n), 32'(1));
    chk("abort_dq_oe", 32'(sram_dq_oe), 32'(0));
    mem_write = 1'b0;
    @(negedge clk);
    @(posedge clk); #1;
    rst = 1'b1;
    @(negedge clk);
    chk("post_reset_ready", 32'(ready), 32'(1));
    chk("post_reset_rdata", rdata, 32'h0);

    issue(1'b1, 1'b0, 32'd1024, 32'h0, mk(LAT, 18'd0, 18'd1, 1'b0, 16'h0, 16'h0, W, 32'hDEADBEEF, 1'b0));
    drop_req();

    repeat (3) @(posedge clk);
    chk("scoreboard_drained", 32'(sb.size()), 32'(0));
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

endmodule
